// File: rtl/gate_op_arbiter_pkg.sv
// Shared types for the gate-op arbiter: opcode and FSM state encodings.
package gate_op_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between the requester agents and the arbiter.
interface gate_op_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 16
) ();
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_ready;
    logic [NUM_REQ*gate_op_pkg::OP_W-1:0]  req_op;
    logic [NUM_REQ*WIDTH-1:0]              req_a;
    logic [NUM_REQ*WIDTH-1:0]              req_b;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [WIDTH-1:0]                      rsp_data;
    logic [ID_W-1:0]                       rsp_id;
    logic                                  rsp_err;
    logic                                  busy;
    logic [CNT_W-1:0]                      done_cnt;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, done_cnt
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, done_cnt
    );

endinterface

// File: rtl/gate_op_arbiter_gate_unit.sv
// Combinational vectorised gate unit; every bit is a 2:1 mux on operand A.
module gate_unit_vec
    import gate_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    always_comb begin
        result_o = '0;
        err_o    = (op_i == OP_RSVD);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (op_i)
                OP_NOT:  result_o[i] = a_i[i] ? 1'b0     : 1'b1;
                OP_AND:  result_o[i] = a_i[i] ? b_i[i]   : 1'b0;
                OP_OR:   result_o[i] = a_i[i] ? 1'b1     : b_i[i];
                OP_NAND: result_o[i] = a_i[i] ? ~b_i[i]  : 1'b1;
                OP_NOR:  result_o[i] = a_i[i] ? 1'b0     : ~b_i[i];
                OP_XOR:  result_o[i] = a_i[i] ? ~b_i[i]  : b_i[i];
                OP_XNOR: result_o[i] = a_i[i] ? b_i[i]   : ~b_i[i];
                default: result_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate unit among NUM_REQ requesters,
// sequenced by an IDLE -> EXEC -> RESP FSM.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_op_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef logic [ID_W-1:0] id_t;

    state_e           state_q;
    id_t              rr_ptr_q;
    id_t              id_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    id_t              rsp_id_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic             gnt_vld;
    id_t              gnt_idx;
    id_t              cand;
    logic [WIDTH-1:0] gu_result;
    logic             gu_err;

    // Search starts at rr_ptr and wraps, so the last winner is checked last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_vld && bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Reset gating keeps req_ready low while rst_n is held, even with valids up.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == IDLE && gnt_vld) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    gate_unit_vec #(
        .WIDTH(WIDTH)
    ) u_gate (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (gu_result),
        .err_o    (gu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= OP_NOT;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        op_q    <= op_e'(bus.req_op[32'(gnt_idx)*OP_W +: OP_W]);
                        a_q     <= bus.req_a[32'(gnt_idx)*WIDTH +: WIDTH];
                        b_q     <= bus.req_b[32'(gnt_idx)*WIDTH +: WIDTH];
                        id_q    <= gnt_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= gu_result;
                    rsp_err_q   <= gu_err;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_W'(1);
                        done_cnt_q  <= done_cnt_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: transaction-level model predicts grants and results.
module tb_gate_op_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam int unsigned C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_op_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .CNT_W(C)) bus ();

    gate_op_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   accepts = 0;
    int   grant_log[$];
    logic [W-1:0] last_data = '0;
    logic         last_err = 1'b0;
    int           last_id = 0;
    logic [7:0]   tbl [7] = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int id, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            3'd0:    e.data = ~a;
            3'd1:    e.data = a & b;
            3'd2:    e.data = a | b;
            3'd3:    e.data = ~(a & b);
            3'd4:    e.data = ~(a | b);
            3'd5:    e.data = a ^ b;
            3'd6:    e.data = ~(a ^ b);
            default: begin e.data = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Monitor / scoreboard
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   acc_cyc = 0;
    bit   m_idle = 1'b1;
    bit   rsp_seen = 1'b0;
    int   win;
    exp_t e;
    logic [W-1:0] h_data;
    logic [1:0]   h_id;
    logic         h_err;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outputs", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err,
                                bus.busy, bus.done_cnt, bus.req_ready}, 64'd0);
            m_ptr = 0; m_cnt = 0; m_idle = 1'b1; rsp_seen = 1'b0; n_done = 0;
            exp_q.delete();
        end else begin
            chk("done_cnt", bus.done_cnt, 64'(m_cnt));
            if (m_idle) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && bus.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
                chk("req_ready_idle", bus.req_ready, (win < 0) ? 64'd0 : (64'd1 << win));
                chk("busy_idle", bus.busy, 64'd0);
                chk("rsp_valid_idle", bus.rsp_valid, 64'd0);
                if (win >= 0) begin
                    exp_q.push_back(model(win, bus.req_op[win*3 +: 3],
                                          bus.req_a[win*W +: W], bus.req_b[win*W +: W]));
                    m_idle = 1'b0;
                    acc_cyc = cyc;
                    rsp_seen = 1'b0;
                end
            end else begin
                chk("req_ready_busy", bus.req_ready, 64'd0);
                chk("busy_active", bus.busy, 64'd1);
                if (!rsp_seen && !bus.rsp_valid && cyc - acc_cyc == 2)
                    chk("rsp_latency_missing", bus.rsp_valid, 64'd1);
                if (bus.rsp_valid) begin
                    if (!rsp_seen) begin
                        chk("rsp_latency", 64'(cyc - acc_cyc), 64'd2);
                        if (exp_q.size() == 0) begin
                            chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                        end else begin
                            chk("rsp_id", bus.rsp_id, 64'(exp_q[0].id));
                            chk("rsp_data", bus.rsp_data, 64'(exp_q[0].data));
                            chk("rsp_err", bus.rsp_err, 64'(exp_q[0].err));
                        end
                        h_data = bus.rsp_data; h_id = bus.rsp_id; h_err = bus.rsp_err;
                        rsp_seen = 1'b1;
                    end else begin
                        chk("rsp_stable", {bus.rsp_data, bus.rsp_id, bus.rsp_err}, {h_data, h_id, h_err});
                    end
                    if (bus.rsp_ready) begin
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            m_ptr = (e.id + 1) % N;
                        end
                        m_cnt = (m_cnt + 1) % (1 << C);
                        m_idle = 1'b1;
                        rsp_seen = 1'b0;
                        last_data = bus.rsp_data;
                        last_err = bus.rsp_err;
                        last_id = int'(bus.rsp_id);
                        n_done++;
                    end
                end
            end
        end
    end

    // Driver
    task automatic post(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_op[i*3 +: 3] = op;
        bus.req_a[i*W +: W]  = a;
        bus.req_b[i*W +: W]  = b;
        bus.req_valid[i]     = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] snap;
        @(negedge clk);
        snap = bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (snap[i]) begin
                bus.req_valid[i] = 1'b0;
                grant_log.push_back(i);
                accepts++;
            end
        end
    endtask

    task automatic drain(input string name);
        int budget = 300;
        bus.rsp_ready = 1'b1;
        while ((bus.req_valid != '0 || bus.busy) && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, {bus.req_valid, bus.busy}, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int target);
        int budget = 40;
        while (n_done < target && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, 64'(n_done), 64'(target));
    endtask

    task automatic rand_run(input string name, input int target, input int cap);
        int budget = 3000;
        accepts = 0;
        while (n_done < target && budget > 0) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0 &&
                    (cap < 0 || accepts + $countones(bus.req_valid) < cap))
                    post(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
            budget--;
        end
        bus.rsp_ready = 1'b1;
        chk(name, 64'(n_done), 64'(target));
    endtask

    initial begin
        int budget;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        do_reset();

        for (int op = 0; op < 7; op++) begin
            post(2, 3'(op), 8'hC5, 8'h3A);
            wait_done("op_done", n_done + 1);
            chk("op_table", {last_err, 8'(last_id), last_data}, {1'b0, 8'd2, tbl[op]});
        end

        post(2, 3'd7, 8'hC5, 8'h3A);
        wait_done("rsvd_done", n_done + 1);
        chk("rsvd_rsp", {last_err, last_data}, {1'b1, 8'h00});
        chk("rsvd_cnt", bus.done_cnt, 64'd8);

        // Reset while a response is pending
        post(1, 3'd5, 8'h0F, 8'hF0);
        post(3, 3'd1, 8'hAA, 8'h55);
        bus.rsp_ready = 1'b0;
        budget = 10;
        while (!bus.rsp_valid && budget > 0) begin
            tick();
            budget--;
        end
        chk("reach_resp", bus.rsp_valid, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err,
                          bus.busy, bus.done_cnt, bus.req_ready}, 64'd0);
        bus.req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // Round-robin with every requester continuously valid
        grant_log.delete();
        for (int i = 0; i < N; i++) post(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        budget = 60;
        while (grant_log.size() < 5 && budget > 0) begin
            tick();
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && grant_log.size() < 5)
                    post(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            budget--;
        end
        chk("rr_count", 64'(grant_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk("rr_order", 64'(grant_log[k]), 64'(k % 4));
        drain("rr_drain");

        // Backpressure
        post(2, 3'd3, 8'h96, 8'h5C);
        bus.rsp_ready = 1'b0;
        budget = 10;
        while (!bus.rsp_valid && budget > 0) begin
            tick();
            budget--;
        end
        post(1, 3'd2, 8'h12, 8'h34);
        repeat (10) tick();
        chk("bp_hold", {bus.rsp_valid, bus.busy, bus.req_ready}, {1'b1, 1'b1, 4'b0000});
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release", {bus.rsp_valid, bus.busy}, 64'd0);
        drain("bp_drain");

        // Counter wrap and random traffic
        do_reset();
        rand_run("rand_17", 17, 17);
        drain("rand_17_drain");
        chk("cnt_wrap", bus.done_cnt, 64'd1);
        rand_run("rand_long", n_done + 60, -1);
        drain("rand_long_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
